// File: rtl/i2c_pkg.sv
// Width/depth constants shared by the APB block, the I2C controller and the byte FIFOs.
package i2c_pkg;
  localparam int I2C_DATA_W     = 8;
  localparam int I2C_FIFO_DEPTH = 16;
endpackage

// File: rtl/i2c_fifo.sv
// Single-clock FWFT byte FIFO between APB and the I2C controller, with optional
// edge-qualified pop so a multi-cycle enable pulse counts as one pop.
module i2c_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = I2C_DATA_W,
  parameter int DEPTH       = I2C_FIFO_DEPTH,
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 2,
  parameter bit POP_ON_EDGE = 1'b0
) (
  input  logic                       core_clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  rd_en_q;
  logic                  pop_req, do_pop, do_push;

  always_comb begin
    pop_req = POP_ON_EDGE ? (rd_en & ~rd_en_q) : rd_en;
    do_pop  = pop_req & ~empty;
    // a push into a full FIFO is still accepted when the same cycle frees a slot
    do_push = wr_en & (~full | do_pop);
  end

  always_ff @(posedge core_clk) begin
    if (!rst_n || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_en && full && !do_pop) overflow  <= 1'b1;
      if (pop_req && empty)         underflow <= 1'b1;
    end
  end

  // storage has no reset; contents survive clear and are masked by empty
  always_ff @(posedge core_clk) begin
    if (rst_n && !clear && do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data      = mem[rd_ptr];
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));
endmodule

// File: tb/tb_i2c_fifo.sv
// Bench for i2c_fifo: one level-pop and one edge-pop instance checked every cycle
// against a sequence-based model, plus directed literal expectations.
module tb_i2c_fifo;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic       rst_n;
  logic       a_clr, a_wr, a_rd, b_clr, b_wr, b_rd;
  logic [7:0] a_wd, b_wd, a_rdata, b_rdata;
  logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [4:0] a_count, b_count;

  i2c_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .POP_ON_EDGE(1'b0)) u_lvl (
    .core_clk(core_clk), .rst_n(rst_n), .clear(a_clr), .wr_en(a_wr), .wr_data(a_wd),
    .rd_en(a_rd), .rd_data(a_rdata), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un));

  i2c_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .POP_ON_EDGE(1'b1)) u_edge (
    .core_clk(core_clk), .rst_n(rst_n), .clear(b_clr), .wr_en(b_wr), .wr_data(b_wd),
    .rd_en(b_rd), .rd_data(b_rdata), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un));

  int compared = 0;
  int mismatched = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted byte gets the next slot of an ever-growing sequence;
  // the live contents are seq[hd .. tl-1].
  logic [7:0] seq [2][4096];
  int         hd [2] = '{0, 0};
  int         tl [2] = '{0, 0};
  bit         ovf_m [2] = '{0, 0};
  bit         unf_m [2] = '{0, 0};
  bit         rq_m [2] = '{0, 0};

  task automatic step(int d, bit rst, bit clr, bit we, logic [7:0] wd, bit re, bit edge_mode);
    int  c;
    bit  pop, popped, push;
    if (!rst || clr) begin
      hd[d] = tl[d]; ovf_m[d] = 0; unf_m[d] = 0; rq_m[d] = 0;
    end else begin
      c      = tl[d] - hd[d];
      pop    = edge_mode ? (re && !rq_m[d]) : re;
      popped = pop && (c > 0);
      push   = we && ((c < DEPTH) || popped);
      if (pop && c == 0) unf_m[d] = 1;
      if (we && !push)   ovf_m[d] = 1;
      if (popped) hd[d]++;
      if (push) begin seq[d][tl[d]] = wd; tl[d]++; end
      rq_m[d] = re;
    end
  endtask

  task automatic cmp(int d, logic [7:0] rdata, logic [4:0] cnt, logic fl, logic em,
                     logic af, logic ae, logic ov, logic un);
    int    c;
    string p;
    c = tl[d] - hd[d];
    p = (d == 0) ? "lvl" : "edge";
    chk({p, ".count"}, 32'(cnt), 32'(c));
    chk({p, ".full"}, 32'(fl), 32'(c == DEPTH));
    chk({p, ".empty"}, 32'(em), 32'(c == 0));
    chk({p, ".almost_full"}, 32'(af), 32'(c >= AF));
    chk({p, ".almost_empty"}, 32'(ae), 32'(c <= AE));
    chk({p, ".overflow"}, 32'(ov), 32'(ovf_m[d]));
    chk({p, ".underflow"}, 32'(un), 32'(unf_m[d]));
    if (c > 0) chk({p, ".rd_data"}, 32'(rdata), 32'(seq[d][hd[d]]));
  endtask

  // inputs change only at negedge, so the model sees what the DUT samples
  always @(posedge core_clk) begin
    step(0, rst_n, a_clr, a_wr, a_wd, a_rd, 1'b0);
    step(1, rst_n, b_clr, b_wr, b_wd, b_rd, 1'b1);
    #1;
    cmp(0, a_rdata, a_count, a_full, a_empty, a_af, a_ae, a_ov, a_un);
    cmp(1, b_rdata, b_count, b_full, b_empty, b_af, b_ae, b_ov, b_un);
  end

  task automatic ca(bit we, logic [7:0] wd, bit re);
    a_wr = we; a_wd = wd; a_rd = re;
    @(negedge core_clk);
  endtask

  task automatic cb(bit we, logic [7:0] wd, bit re);
    b_wr = we; b_wd = wd; b_rd = re;
    @(negedge core_clk);
  endtask

  initial begin
    logic [7:0] v3 [3];
    logic [7:0] nxt, expv;
    int         c;
    bit         we, re;

    rst_n = 0; a_clr = 0; a_wr = 0; a_rd = 0; a_wd = 0;
    b_clr = 0; b_wr = 0; b_rd = 0; b_wd = 0;
    @(negedge core_clk); @(negedge core_clk);
    rst_n = 1;
    chk("reset.count", 32'(a_count), 0);
    chk("reset.empty", 32'(a_empty), 1);
    chk("reset.full", 32'(a_full), 0);
    chk("reset.almost_empty", 32'(a_ae), 1);
    chk("reset.almost_full", 32'(a_af), 0);
    chk("reset.flags", 32'({a_ov, a_un, b_ov, b_un}), 0);

    // basic FWFT push/pop
    ca(1, 8'h11, 0);
    chk("fwft.first", 32'(a_rdata), 32'h11);
    chk("fwft.empty", 32'(a_empty), 0);
    ca(1, 8'h22, 0); ca(1, 8'h33, 0);
    chk("fwft.count3", 32'(a_count), 3);
    v3[0] = 8'h11; v3[1] = 8'h22; v3[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      chk("fwft.pop", 32'(a_rdata), 32'(v3[i]));
      ca(0, 0, 1);
    end
    chk("fwft.empty_after", 32'(a_empty), 1);

    // fill, overflow, push-while-full-with-pop, drain
    for (int i = 0; i < 16; i++) begin
      ca(1, 8'(i), 0);
      chk("fill.almost_full", 32'(a_af), 32'(i + 1 >= 12));
    end
    chk("fill.full", 32'(a_full), 1);
    ca(1, 8'hAA, 0);
    chk("fill.overflow", 32'(a_ov), 1);
    chk("fill.count16", 32'(a_count), 16);
    chk("full_pp.head", 32'(a_rdata), 32'h00);
    ca(1, 8'h55, 1);
    chk("full_pp.count", 32'(a_count), 16);
    for (int i = 1; i < 16; i++) begin
      chk("drain.data", 32'(a_rdata), 32'(i));
      ca(0, 0, 1);
    end
    chk("drain.last55", 32'(a_rdata), 32'h55);
    ca(0, 0, 1);
    chk("drain.empty", 32'(a_empty), 1);

    // underflow, push+pop while empty, clear
    ca(0, 0, 1);
    chk("uf.underflow", 32'(a_un), 1);
    ca(1, 8'h77, 1);
    chk("uf.pp_count", 32'(a_count), 1);
    chk("uf.pp_data", 32'(a_rdata), 32'h77);
    a_clr = 1; ca(0, 0, 0); a_clr = 0;
    chk("clear.count", 32'(a_count), 0);
    chk("clear.flags", 32'({a_ov, a_un}), 0);

    // interleaved traffic across the pointer wrap, occupancy kept at 1..3
    nxt = 8'h00; expv = 8'h00;
    ca(1, nxt, 0); nxt++;
    for (int i = 0; i < 40; i++) begin
      c  = tl[0] - hd[0];
      we = (c < 3) && (c <= 1 || $urandom_range(0, 3) != 0);
      re = (c == 3) || (c > 1 && $urandom_range(0, 1) == 1);
      if (re) begin
        chk("wrap.seq", 32'(a_rdata), 32'(expv));
        expv++;
      end
      ca(we, nxt, re);
      if (we) nxt++;
    end
    while (tl[0] - hd[0] > 0) begin
      chk("wrap.drain", 32'(a_rdata), 32'(expv));
      expv++;
      ca(0, 0, 1);
    end
    chk("wrap.advanced", 32'(expv > 8'd16), 1);

    // random traffic on both instances, occasional clear
    for (int i = 0; i < 400; i++) begin
      a_wr = 1'($urandom_range(0, 1)); a_wd = 8'($urandom); a_rd = ($urandom_range(0, 2) == 0);
      b_wr = 1'($urandom_range(0, 1)); b_wd = 8'($urandom); b_rd = 1'($urandom_range(0, 1));
      a_clr = ($urandom_range(0, 60) == 0);
      b_clr = ($urandom_range(0, 60) == 0);
      @(negedge core_clk);
    end
    a_clr = 1; b_clr = 1; a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
    @(negedge core_clk);
    a_clr = 0; b_clr = 0;

    // edge-qualified pop
    for (int i = 0; i < 4; i++) cb(1, 8'hC0 + 8'(i), 0);
    chk("edge.count4", 32'(b_count), 4);
    for (int i = 0; i < 5; i++) cb(0, 0, 1);
    chk("edge.held_one_pop", 32'(b_count), 3);
    chk("edge.head", 32'(b_rdata), 32'hC1);
    cb(0, 0, 0); cb(0, 0, 1);
    chk("edge.second_pop", 32'(b_count), 2);
    chk("edge.head2", 32'(b_rdata), 32'hC2);
    cb(0, 0, 0);

    // reset in the middle of a push
    for (int i = 0; i < 5; i++) ca(1, 8'h50 + 8'(i), 0);
    chk("rst.count5", 32'(a_count), 5);
    a_wr = 1; a_wd = 8'hEE; rst_n = 0;
    @(negedge core_clk);
    rst_n = 1; a_wr = 0;
    chk("rst.count", 32'(a_count), 0);
    chk("rst.empty", 32'(a_empty), 1);
    ca(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
